tape_ctrl: RTL and testbench
============================

TAPE_CTRL -- requirements
Module: tape_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning tape cell width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, meaning tape pointer width; tape depth is 2^ADDR_WIDTH.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd  input  3  data-side command code.
REQ-006 SHALL have port cmd_valid  input  1  command offered.
REQ-007 SHALL have port cmd_ready  output  1  command accepted this cycle when high with cmd_valid.
REQ-008 SHALL have port cell_zero  output  1  current cell equals 0, for loop branch decisions.
REQ-009 SHALL have port ptr  output  ADDR_WIDTH  current tape pointer.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  byte for the '.' command.
REQ-011 SHALL have port out_valid / out_ready  output / input  1 each  output-byte handshake.
REQ-012 SHALL have port in_data  input  DATA_WIDTH  byte for the ',' command.
REQ-013 SHALL have port in_valid / in_ready  input / output  1 each  input-byte handshake.
REQ-014 SHALL have port err  output  1  sticky pointer range error.

Function
REQ-015 SHALL decode commands as PINC=0, PDEC=1, CINC=2, CDEC=3, OUT=4, IN=5, NOP=6, CLR=7.
REQ-016 SHALL implement the FSM states IDLE, WAIT_OUT, WAIT_IN, CLEAR, HALT.
REQ-017 SHALL drive cmd_ready high only in IDLE.
REQ-018 SHALL execute PINC, PDEC, CINC, CDEC and NOP at the accepting edge, remain in IDLE, and sustain one command per cycle.
REQ-019 SHALL apply PINC/PDEC as ptr ±1 and CINC/CDEC as cell ±1 modulo 2^DATA_WIDTH; 255+1 gives 0 and 0-1 gives 255.
REQ-020 SHALL, on OUT accept, register the current cell into out_data, enter WAIT_OUT with out_valid=1, and return to IDLE on the edge where out_valid && out_ready.
REQ-021 SHALL, on IN accept, enter WAIT_IN with in_ready=1, write in_data into the current cell on the edge where in_valid && in_ready, and return to IDLE.
REQ-022 SHALL, on CLR accept, enter CLEAR and write 0 to addresses 0..2^ADDR_WIDTH-1, one per cycle, from an internal counter.
REQ-023 SHALL leave ptr unchanged across CLEAR and return to IDLE after exactly 2^ADDR_WIDTH cycles.
REQ-024 SHALL treat the tape memory as written every cycle; on every non-writing cycle it SHALL drive write data equal to the read data at the driven address, so the cell holds.
REQ-025 SHALL compute cell_zero combinationally from the read data at ptr; it is meaningful only in IDLE.
REQ-026 SHALL ignore cmd_valid while cmd_ready is low; no command is queued.

Reset
REQ-027 SHALL, while nrst is low, force state=IDLE, ptr=0, out_valid=0, out_data=0, in_ready=0, err=0 and the clear counter to 0; cmd_ready is 1 after release.
REQ-028 SHALL abort any OUT, IN or CLEAR on reset mid-operation; tape contents SHALL be zeroed by the memory's own reset.

Configuration
REQ-029 SHALL, with TAPE_WRAP_EN defined, wrap ptr modulo 2^ADDR_WIDTH (63 PINC gives 0, 0 PDEC gives 63) and tie err to 0.
REQ-030 SHALL, without TAPE_WRAP_EN, treat PINC at max or PDEC at 0 as follows: ptr is unchanged, err is set, and the FSM enters HALT (cmd_ready=0) until reset.

Structure
REQ-031 SHALL take the command codes and FSM state enum from shared package bf_pkg.
REQ-032 SHALL instantiate exactly one sub-module, the existing RAM tape memory, with clk/nrst and DATA_WIDTH/ADDR_WIDTH passed through.

Verification
REQ-033 SHALL cover: reset, then CINC ×3, PINC, CINC, PDEC -> ptr=0, cell0=3, cell1=1, cell_zero=0.
REQ-034 SHALL cover: CDEC on a zero cell -> cell=255; CINC -> cell=0 and cell_zero=1.
REQ-035 SHALL cover: cell=0x41, then OUT with out_ready held low 5 cycles -> out_valid=1 and out_data=0x41 held, cmd_ready=0; out_ready=1 -> IDLE next cycle.
REQ-036 SHALL cover: IN with in_valid delayed 3 cycles and in_data=0x7F -> cell=0x7F, neighbour cells unchanged.
REQ-037 SHALL cover: cells 0..5 nonzero, ptr=5, CLR -> cmd_ready low exactly 64 cycles, all cells 0, ptr=5.
REQ-038 SHALL cover: PDEC at ptr=0 -> ptr=63 with TAPE_WRAP_EN; without it ptr=0, err=1, cmd_ready=0 until nrst pulses.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared command codes and controller state encoding for the tape
// controller family.
package bf_pkg;

  typedef enum logic [2:0] {
    CMD_PINC = 3'd0,
    CMD_PDEC = 3'd1,
    CMD_CINC = 3'd2,
    CMD_CDEC = 3'd3,
    CMD_OUT  = 3'd4,
    CMD_IN   = 3'd5,
    CMD_NOP  = 3'd6,
    CMD_CLR  = 3'd7
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_OUT = 3'd1,
    ST_WAIT_IN  = 3'd2,
    ST_CLEAR    = 3'd3,
    ST_HALT     = 3'd4
  } state_e;

endpackage

// File: rtl/tape_ctrl_ram.sv
// Tape memory: written every cycle at addr, asynchronous read, contents
// zeroed by nrst.
module tape_ctrl_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  assign rdata = mem_r[addr];

  // Cell storage; the controller holds a cell by writing back its read data.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      mem_r[addr] <= wdata;
    end
  end

endmodule

// File: rtl/tape_ctrl.sv
// Tape controller: executes pointer/cell commands against the tape memory
// with byte in/out handshakes. Define TAPE_WRAP_EN to let the pointer wrap
// instead of halting with err on a range violation.
module tape_ctrl
  import bf_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [2:0]            cmd,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic                  cell_zero,
  output logic [ADDR_WIDTH-1:0] ptr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] PTR_MAX = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] CELL_ONE = DATA_WIDTH'(1);

  state_e                state_r;
  logic [ADDR_WIDTH-1:0] ptr_r;
  logic [ADDR_WIDTH-1:0] clr_cnt_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic                  out_valid_r;
  logic                  in_ready_r;
  logic                  cmd_ready_r;
  logic                  err_r;

  cmd_e                  cmd_s;
  logic                  accept_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic [DATA_WIDTH-1:0] wdata_s;
  logic [DATA_WIDTH-1:0] rdata_s;

  assign cmd_s     = cmd_e'(cmd);
  assign accept_s  = cmd_valid && cmd_ready_r;
  assign cell_zero = (rdata_s == '0);
  assign cmd_ready = cmd_ready_r;
  assign ptr       = ptr_r;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign in_ready  = in_ready_r;
  assign err       = err_r;

  // Memory port: clear sweep owns the address in CLEAR, otherwise ptr; hold by default.
  always_comb begin
    addr_s  = ptr_r;
    wdata_s = rdata_s;
    if (state_r == ST_CLEAR) begin
      addr_s  = clr_cnt_r;
      wdata_s = '0;
    end else if (state_r == ST_WAIT_IN && in_valid && in_ready_r) begin
      wdata_s = in_data;
    end else if (accept_s && cmd_s == CMD_CINC) begin
      wdata_s = rdata_s + CELL_ONE;
    end else if (accept_s && cmd_s == CMD_CDEC) begin
      wdata_s = rdata_s - CELL_ONE;
    end else begin
      wdata_s = rdata_s;
    end
  end

  // Controller FSM with all handshake outputs registered.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r     <= ST_IDLE;
      ptr_r       <= '0;
      clr_cnt_r   <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
      cmd_ready_r <= 1'b1;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            case (cmd_s)
              CMD_PINC: begin
`ifdef TAPE_WRAP_EN
                ptr_r <= ptr_r + PTR_ONE;
`else
                if (ptr_r == PTR_MAX) begin
                  err_r       <= 1'b1;
                  state_r     <= ST_HALT;
                  cmd_ready_r <= 1'b0;
                end else begin
                  ptr_r <= ptr_r + PTR_ONE;
                end
`endif
              end
              CMD_PDEC: begin
`ifdef TAPE_WRAP_EN
                ptr_r <= ptr_r - PTR_ONE;
`else
                if (ptr_r == '0) begin
                  err_r       <= 1'b1;
                  state_r     <= ST_HALT;
                  cmd_ready_r <= 1'b0;
                end else begin
                  ptr_r <= ptr_r - PTR_ONE;
                end
`endif
              end
              CMD_OUT: begin
                out_data_r  <= rdata_s;
                out_valid_r <= 1'b1;
                cmd_ready_r <= 1'b0;
                state_r     <= ST_WAIT_OUT;
              end
              CMD_IN: begin
                in_ready_r  <= 1'b1;
                cmd_ready_r <= 1'b0;
                state_r     <= ST_WAIT_IN;
              end
              CMD_CLR: begin
                clr_cnt_r   <= '0;
                cmd_ready_r <= 1'b0;
                state_r     <= ST_CLEAR;
              end
              CMD_CINC, CMD_CDEC, CMD_NOP: begin
                state_r <= ST_IDLE;
              end
              default: begin
                state_r <= ST_IDLE;
              end
            endcase
          end
        end
        ST_WAIT_OUT: begin
          if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        ST_WAIT_IN: begin
          if (in_valid && in_ready_r) begin
            in_ready_r  <= 1'b0;
            cmd_ready_r <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          // One address per cycle; the last address returns to IDLE.
          clr_cnt_r <= clr_cnt_r + PTR_ONE;
          if (clr_cnt_r == PTR_MAX) begin
            cmd_ready_r <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        ST_HALT: begin
          cmd_ready_r <= 1'b0;
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b0;
          cmd_ready_r <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  tape_ctrl_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .nrst  (nrst),
    .addr  (addr_s),
    .wdata (wdata_s),
    .rdata (rdata_s)
  );

endmodule

// File: tb/tb_tape_ctrl.sv
// Directed bench for tape_ctrl; cells are observed through the OUT command.
module tb_tape_ctrl;
  import bf_pkg::*;

  logic       clk;
  logic       nrst;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cell_zero;
  logic [5:0] ptr;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  tape_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cell_zero (cell_zero),
    .ptr       (ptr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic issue(input cmd_e c);
    @(negedge clk);
    cmd       = c;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic read_cell(output logic [7:0] val);
    bit seen;
    seen = 1'b0;
    val  = 8'h00;
    issue(CMD_OUT);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("out_valid_timeout", {31'd0, seen}, 32'd1);
    val       = out_data;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
  endtask

  logic [7:0] v;
  int         low_cnt;

  initial begin
    nrst = 1'b0; cmd = 3'd0; cmd_valid = 1'b0; out_ready = 1'b0;
    in_data = 8'h00; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_ptr", {26'd0, ptr}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_cell_zero", {31'd0, cell_zero}, 32'd1);

    // CINC x3, PINC, CINC, PDEC
    issue(CMD_CINC); issue(CMD_CINC); issue(CMD_CINC);
    issue(CMD_PINC); issue(CMD_CINC); issue(CMD_PDEC);
    @(negedge clk);
    check("seq_ptr", {26'd0, ptr}, 32'd0);
    check("seq_cell_zero", {31'd0, cell_zero}, 32'd0);
    read_cell(v);
    check("seq_cell0", {24'd0, v}, 32'd3);
    issue(CMD_PINC);
    read_cell(v);
    check("seq_cell1", {24'd0, v}, 32'd1);

    // Cell wrap on cell 2
    issue(CMD_PINC);
    issue(CMD_CDEC);
    read_cell(v);
    check("cdec_wrap", {24'd0, v}, 32'd255);
    issue(CMD_CINC);
    @(negedge clk);
    check("cinc_wrap_zero", {31'd0, cell_zero}, 32'd1);
    read_cell(v);
    check("cinc_wrap_val", {24'd0, v}, 32'd0);

    // OUT with back-pressure, cell 2 = 0x41
    for (int i = 0; i < 65; i++) issue(CMD_CINC);
    issue(CMD_OUT);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_data", {24'd0, out_data}, 32'h41);
      check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("bp_idle_ready", {31'd0, cmd_ready}, 32'd1);
    check("bp_out_valid_low", {31'd0, out_valid}, 32'd0);

    // IN with delayed in_valid
    issue(CMD_IN);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("in_wait_ready", {31'd0, in_ready}, 32'd1);
      check("in_wait_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    in_data  = 8'h7F;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("in_done_ready", {31'd0, cmd_ready}, 32'd1);
    read_cell(v);
    check("in_cell2", {24'd0, v}, 32'h7F);
    issue(CMD_PDEC);
    read_cell(v);
    check("in_nbr_cell1", {24'd0, v}, 32'd1);
    issue(CMD_PINC); issue(CMD_PINC);
    read_cell(v);
    check("in_nbr_cell3", {24'd0, v}, 32'd0);

    // Make cells 3..5 nonzero, ptr=5, then CLR
    issue(CMD_CINC);
    issue(CMD_PINC); issue(CMD_CINC);
    issue(CMD_PINC); issue(CMD_CINC);
    read_cell(v);
    check("pre_clr_cell5", {24'd0, v}, 32'd1);
    issue(CMD_CLR);
    low_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) break;
      low_cnt++;
    end
    check("clr_low_cycles", low_cnt, 32'd64);
    check("clr_ptr", {26'd0, ptr}, 32'd5);
    for (int a = 5; a >= 0; a--) begin
      read_cell(v);
      check($sformatf("clr_cell%0d", a), {24'd0, v}, 32'd0);
      if (a > 0) issue(CMD_PDEC);
    end
    @(negedge clk);
    check("clr_end_ptr", {26'd0, ptr}, 32'd0);

    // PDEC at ptr=0
    issue(CMD_PDEC);
    @(negedge clk);
`ifdef TAPE_WRAP_EN
    check("wrap_ptr", {26'd0, ptr}, 32'd63);
    check("wrap_err", {31'd0, err}, 32'd0);
    check("wrap_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    issue(CMD_PINC);
    @(negedge clk);
    check("wrap_back_ptr", {26'd0, ptr}, 32'd0);
`else
    check("halt_ptr", {26'd0, ptr}, 32'd0);
    check("halt_err", {31'd0, err}, 32'd1);
    check("halt_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    issue(CMD_PINC);
    repeat (3) @(negedge clk);
    check("halt_hold_ready", {31'd0, cmd_ready}, 32'd0);
    check("halt_hold_ptr", {26'd0, ptr}, 32'd0);
    check("halt_hold_err", {31'd0, err}, 32'd1);
    pulse_reset();
    check("halt_rst_err", {31'd0, err}, 32'd0);
    check("halt_rst_ready", {31'd0, cmd_ready}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
